// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: round-robin shared serial pattern detector with per-channel match counters
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req[NUM_CH]       per-channel bit-valid request (held until granted)
//   din[NUM_CH]       per-channel serial bit, consumed only when granted
//   gnt[NUM_CH]       one-hot combinational grant, zero when no request
//   match_valid       registered pulse: the granted bit completed PATTERN
//   match_ch          channel index of the match, valid with match_valid
//   clr               synchronous clear of all match counters
//   rd_ch, rd_count   counter read select and registered count (1-cycle latency)
// Build option: define SEQ_SCHED_CNT_SAT_EN to make counters saturate instead of wrap.
module seq_detect_scheduler #(
  parameter int NUM_CH = 4,
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int SEEN_W = $clog2(PAT_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] gnt,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic              clr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_count
);
  logic [CH_W-1:0]    r_ptr;
  logic [PAT_LEN-2:0] r_hist [NUM_CH];
  logic [SEEN_W-1:0]  r_seen [NUM_CH];
  logic [CNT_W-1:0]   r_cnt  [NUM_CH];
  logic               r_match_valid;
  logic [CH_W-1:0]    r_match_ch;
  logic [CNT_W-1:0]   r_rd_count;
  logic               w_found;
  logic [CH_W-1:0]    w_idx;
  logic [CH_W-1:0]    w_j;
  logic [CH_W-1:0]    w_ptr_nxt;
  logic [PAT_LEN-1:0] w_shift;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_nxt;
  // scan from r_ptr upward with wrap; first requester wins
  always_comb begin
    w_found = 1'b0;
    w_idx = '0;
    w_j = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_j = CH_W'((int'(r_ptr) + i) % NUM_CH);
      if (!w_found && req[w_j]) begin
        w_found = 1'b1;
        w_idx = w_j;
      end
    end
  end
  assign gnt = w_found ? (NUM_CH'(1) << w_idx) : '0;
  assign w_ptr_nxt = (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + CH_W'(1);
  // shifted history doubles as the compare window; low PAT_LEN-1 bits become the new history
  assign w_shift = {r_hist[w_idx], din[w_idx]};
  assign w_match = w_found && (w_shift == PATTERN) && (r_seen[w_idx] == SEEN_W'(PAT_LEN - 1));
`ifdef SEQ_SCHED_CNT_SAT_EN
  assign w_cnt_nxt = (&r_cnt[w_idx]) ? r_cnt[w_idx] : r_cnt[w_idx] + CNT_W'(1);
`else
  assign w_cnt_nxt = r_cnt[w_idx] + CNT_W'(1);
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_match_valid <= 1'b0;
      r_match_ch <= '0;
      r_rd_count <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_hist[k] <= '0;
        r_seen[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      r_match_valid <= w_match;
      r_rd_count <= r_cnt[rd_ch];
      if (w_match)
        r_match_ch <= w_idx;
      if (w_found) begin
        r_ptr <= w_ptr_nxt;
        r_hist[w_idx] <= w_shift[PAT_LEN-2:0];
        if (r_seen[w_idx] != SEEN_W'(PAT_LEN - 1))
          r_seen[w_idx] <= r_seen[w_idx] + SEEN_W'(1);
      end
      // clear wins over a coincident increment
      if (clr) begin
        for (int k = 0; k < NUM_CH; k++)
          r_cnt[k] <= '0;
      end else if (w_match) begin
        r_cnt[w_idx] <= w_cnt_nxt;
      end
    end
  end
  assign match_valid = r_match_valid;
  assign match_ch = r_match_ch;
  assign rd_count = r_rd_count;
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler: directed self-checking bench for seq_detect_scheduler
module tb_seq_detect_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic       clr = 1'b0;
  logic [1:0] rd_ch = '0;
  logic [3:0] gnt, gnt2;
  logic       match_valid, match_valid2;
  logic [1:0] match_ch, match_ch2;
  logic [7:0] rd_count;
  logic [1:0] rd_count2;
  int checks = 0;
  int errors = 0;
  int n;
  logic [15:0] s;
  seq_detect_scheduler u_dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
    .match_valid(match_valid), .match_ch(match_ch), .clr(clr),
    .rd_ch(rd_ch), .rd_count(rd_count)
  );
  seq_detect_scheduler #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt2),
    .match_valid(match_valid2), .match_ch(match_ch2), .clr(clr),
    .rd_ch(rd_ch), .rd_count(rd_count2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic [3:0] rq, input logic [3:0] d, input logic [3:0] eg);
    req = rq;
    din = d;
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    tick();
  endtask
  task automatic do_reset();
    req = '0;
    din = '0;
    clr = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mv", 32'(match_valid), 0);
    chk("rst_rd", 32'(rd_count), 0);
    reset = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_mv0", 32'(match_valid), 0);
    chk("rst_mch0", 32'(match_ch), 0);
    chk("rst_rd0", 32'(rd_count), 0);
    chk("rst_gnt0", 32'(gnt), 0);
    reset = 1'b0;
    // single channel 0110 on ch0
    step(4'b0001, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    chk("single_nomatch", 32'(match_valid), 0);
    step(4'b0001, 4'b0000, 4'b0001);
    chk("single_mv", 32'(match_valid), 1);
    chk("single_mch", 32'(match_ch), 0);
    req = '0;
    rd_ch = 2'd0;
    tick();
    chk("single_mv_drop", 32'(match_valid), 0);
    chk("single_cnt", 32'(rd_count), 1);
    // overlapping 0110110 on ch2
    step(4'b0100, 4'b0000, 4'b0100);
    step(4'b0100, 4'b0100, 4'b0100);
    step(4'b0100, 4'b0100, 4'b0100);
    step(4'b0100, 4'b0000, 4'b0100);
    chk("ovl_mv1", 32'(match_valid), 1);
    chk("ovl_mch1", 32'(match_ch), 2);
    step(4'b0100, 4'b0100, 4'b0100);
    chk("ovl_gap1", 32'(match_valid), 0);
    step(4'b0100, 4'b0100, 4'b0100);
    chk("ovl_gap2", 32'(match_valid), 0);
    step(4'b0100, 4'b0000, 4'b0100);
    chk("ovl_mv2", 32'(match_valid), 1);
    chk("ovl_mch2", 32'(match_ch), 2);
    req = '0;
    rd_ch = 2'd2;
    tick();
    chk("ovl_cnt", 32'(rd_count), 2);
    // fairness from reset
    do_reset();
    step(4'b1111, 4'b0000, 4'b0001);
    step(4'b1111, 4'b0000, 4'b0010);
    step(4'b1111, 4'b0000, 4'b0100);
    step(4'b1111, 4'b0000, 4'b1000);
    step(4'b1111, 4'b0000, 4'b0001);
    step(4'b1111, 4'b0000, 4'b0010);
    step(4'b1111, 4'b0000, 4'b0100);
    step(4'b1111, 4'b0000, 4'b1000);
    step(4'b0001, 4'b0000, 4'b0001);
    step(4'b0010, 4'b0000, 4'b0010);
    step(4'b1010, 4'b0000, 4'b1000);
    step(4'b1010, 4'b0000, 4'b0010);
    step(4'b0000, 4'b0000, 4'b0000);
    // interleaved ch0/ch1, each holding its bit until granted
    do_reset();
    step(4'b0011, 4'b0000, 4'b0001);
    step(4'b0011, 4'b0001, 4'b0010);
    step(4'b0011, 4'b0011, 4'b0001);
    step(4'b0011, 4'b0011, 4'b0010);
    step(4'b0011, 4'b0011, 4'b0001);
    step(4'b0011, 4'b0010, 4'b0010);
    chk("intl_nomatch", 32'(match_valid), 0);
    step(4'b0011, 4'b0000, 4'b0001);
    chk("intl_mv0", 32'(match_valid), 1);
    chk("intl_mch0", 32'(match_ch), 0);
    step(4'b0010, 4'b0000, 4'b0010);
    chk("intl_mv1", 32'(match_valid), 1);
    chk("intl_mch1", 32'(match_ch), 1);
    req = '0;
    rd_ch = 2'd0;
    tick();
    chk("intl_cnt0", 32'(rd_count), 1);
    rd_ch = 2'd1;
    tick();
    chk("intl_cnt1", 32'(rd_count), 1);
    // clr coincident with a match on ch3
    do_reset();
    rd_ch = 2'd3;
    step(4'b1000, 4'b0000, 4'b1000);
    step(4'b1000, 4'b1000, 4'b1000);
    step(4'b1000, 4'b1000, 4'b1000);
    step(4'b1000, 4'b0000, 4'b1000);
    req = '0;
    tick();
    chk("clr_pre_cnt", 32'(rd_count), 1);
    step(4'b1000, 4'b1000, 4'b1000);
    step(4'b1000, 4'b1000, 4'b1000);
    clr = 1'b1;
    step(4'b1000, 4'b0000, 4'b1000);
    clr = 1'b0;
    chk("clr_mv", 32'(match_valid), 1);
    chk("clr_mch", 32'(match_ch), 3);
    chk("clr_rd_pre", 32'(rd_count), 1);
    req = '0;
    tick();
    chk("clr_cnt", 32'(rd_count), 0);
    // five matches on ch0: wrap or saturate in the 2-bit counter
    do_reset();
    rd_ch = 2'd0;
    s = 16'b0110110110110110;
    n = 0;
    for (int i = 15; i >= 0; i--) begin
      step(4'b0001, {3'b000, s[i]}, 4'b0001);
      if (match_valid) n++;
    end
    chk("wrap_pulses", 32'(n), 5);
    req = '0;
    tick();
    chk("wrap_cnt8", 32'(rd_count), 5);
`ifdef SEQ_SCHED_CNT_SAT_EN
    chk("wrap_cnt2", 32'(rd_count2), 3);
`else
    chk("wrap_cnt2", 32'(rd_count2), 1);
`endif
    // asynchronous reset drops a pending pulse and clears history
    step(4'b0001, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0000, 4'b0001);
    chk("mid_mv", 32'(match_valid), 1);
    do_reset();
    step(4'b0001, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    do_reset();
    step(4'b0001, 4'b0000, 4'b0001);
    chk("mid_after_rst", 32'(match_valid), 0);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0001, 4'b0001);
    chk("mid_partial", 32'(match_valid), 0);
    step(4'b0001, 4'b0000, 4'b0001);
    chk("mid_full", 32'(match_valid), 1);
    chk("mid_full_ch", 32'(match_ch), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
